// File: rtl/fetch_sequencer_pkg.sv
// Shared fetch-stage definitions: default widths, reset PC, fetch state encodings
// and the opcode constants that the control unit also decodes.
package fetch_sequencer_pkg;

   localparam int          DEF_PC_W     = 16;
   localparam int          DEF_INSTR_W  = 16;
   localparam logic [15:0] DEF_RESET_PC = 16'h0000;

   // Legacy-compatible fetch state encodings
   localparam logic [1:0] ST_FETCH  = 2'd0;
   localparam logic [1:0] ST_HALTED = 2'd1;
   localparam logic [1:0] ST_FAULT  = 2'd2;

   typedef logic [1:0] fetch_state_t;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_BEQ  = 4'h8;
   localparam logic [3:0] OP_BNE  = 4'h9;
   localparam logic [3:0] OP_JMP  = 4'hC;
   localparam logic [3:0] OP_HALT = 4'hF;

endpackage

// File: rtl/fetch_sequencer_skid_buf.sv
// One-entry {instr, pc, valid} holding buffer that catches an instruction
// returned by memory while decode is stalled.
module fetch_sequencer_skid_buf
   import fetch_sequencer_pkg::*;
#(
   parameter int PC_W    = DEF_PC_W,
   parameter int INSTR_W = DEF_INSTR_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_load,
   input  logic               i_pop,
   input  logic               i_clear,
   input  logic [INSTR_W-1:0] i_instr,
   input  logic [PC_W-1:0]    i_pc,
   output logic [INSTR_W-1:0] o_instr,
   output logic [PC_W-1:0]    o_pc,
   output logic               o_valid
);

   logic [INSTR_W-1:0] r_instr;
   logic [PC_W-1:0]    r_pc;
   logic               r_valid;

   // Clear beats load beats pop; the data fields only move on a load.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_instr <= '0;
         r_pc    <= '0;
         r_valid <= 1'b0;
      end else if (i_clear) begin
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_instr <= i_instr;
         r_pc    <= i_pc;
         r_valid <= 1'b1;
      end else if (i_pop) begin
         r_valid <= 1'b0;
      end
   end

   assign o_instr = r_instr;
   assign o_pc    = r_pc;
   assign o_valid = r_valid;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch stage: owns the PC, runs the req/ack instruction-memory port
// and fills the IF/ID register, applying redirects, halt, fault and stalls.
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter int              PC_W     = DEF_PC_W,
   parameter int              INSTR_W  = DEF_INSTR_W,
   parameter logic [PC_W-1:0] RESET_PC = DEF_RESET_PC
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stall,
   input  logic               pc_op,
   input  logic               b_jmp,
   input  logic               if_flush,
   input  logic               halt,
   input  logic               ovf_err,
   input  logic [PC_W-1:0]    br_offset,
   input  logic [PC_W-1:0]    jmp_target,
   output logic [PC_W-1:0]    imem_addr,
   output logic               imem_req,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] ifid_instr,
   output logic [PC_W-1:0]    ifid_pc,
   output logic               ifid_valid,
   output logic               halted,
   output logic               fault,
   output logic [1:0]         o_dbg_state
);

   localparam logic [PC_W-1:0] PC_STEP = PC_W'(2);

   // Memory handshake: a request is raised with imem_req=1 and imem_addr valid;
   // both stay put until the cycle imem_ack=1 (possibly the same cycle). An ack
   // only counts while imem_req=1; acks seen with imem_req=0 are ignored.

   fetch_state_t       r_state;
   logic [PC_W-1:0]    r_pc;
   logic               r_pending;
   logic               r_drop;
   logic [PC_W-1:0]    r_drop_addr;
   logic [INSTR_W-1:0] r_ifid_instr;
   logic [PC_W-1:0]    r_ifid_pc;
   logic               r_ifid_valid;
   logic               r_halted;
   logic               r_fault;

   logic               w_in_fetch;
   logic               w_req;
   logic               w_ack;
   logic               w_take;
   logic               w_pend_next;
   logic               w_drop_next;
   logic [PC_W-1:0]    w_pc_seq;
   logic [PC_W-1:0]    w_br_target;
   logic [PC_W-1:0]    w_target;
   logic               w_fetch_ok;
   logic               w_skid_load;
   logic               w_skid_pop;
   logic               w_skid_clear;
   logic [INSTR_W-1:0] w_skid_instr;
   logic [PC_W-1:0]    w_skid_pc;
   logic               w_skid_full;

   assign w_in_fetch = (r_state == ST_FETCH);

   // An outstanding or dropped request keeps req high regardless of stall/skid.
   assign w_req  = reset && w_in_fetch &&
                   (r_drop || r_pending || (!stall && !w_skid_full));
   assign w_ack  = w_req && imem_ack;
   assign w_take = w_ack && !r_drop;

   assign w_pend_next = w_req && !imem_ack && !r_drop;
   assign w_drop_next = r_drop && !imem_ack;

   assign w_pc_seq    = r_pc + PC_STEP;
   assign w_br_target = r_ifid_pc + PC_STEP + (br_offset << 1);
   assign w_target    = b_jmp ? w_br_target : jmp_target;

   assign w_fetch_ok   = w_in_fetch && !ovf_err && !halt && !pc_op && !if_flush;
   assign w_skid_load  = w_fetch_ok && stall && w_take;
   assign w_skid_pop   = w_fetch_ok && !stall && w_skid_full;
   assign w_skid_clear = !w_in_fetch || ovf_err || halt || pc_op;

   fetch_sequencer_skid_buf #(
      .PC_W    (PC_W),
      .INSTR_W (INSTR_W)
   ) u_skid (
      .clk     (clk),
      .reset   (reset),
      .i_load  (w_skid_load),
      .i_pop   (w_skid_pop),
      .i_clear (w_skid_clear),
      .i_instr (imem_rdata),
      .i_pc    (r_pc),
      .o_instr (w_skid_instr),
      .o_pc    (w_skid_pc),
      .o_valid (w_skid_full)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state      <= ST_FETCH;
         r_pc         <= RESET_PC;
         r_pending    <= 1'b0;
         r_drop       <= 1'b0;
         r_drop_addr  <= '0;
         r_ifid_instr <= '0;
         r_ifid_pc    <= '0;
         r_ifid_valid <= 1'b0;
         r_halted     <= 1'b0;
         r_fault      <= 1'b0;
      end else if (ovf_err) begin
         r_state      <= ST_FAULT;
         r_fault      <= 1'b1;
         r_halted     <= 1'b1;
         r_ifid_valid <= 1'b0;
         r_pending    <= 1'b0;
         r_drop       <= 1'b0;
      end else if (!w_in_fetch) begin
         r_ifid_valid <= 1'b0;
         r_pending    <= 1'b0;
         r_drop       <= 1'b0;
      end else if (halt) begin
         r_state      <= ST_HALTED;
         r_halted     <= 1'b1;
         r_ifid_valid <= 1'b0;
         r_pending    <= 1'b0;
         r_drop       <= 1'b0;
      end else if (pc_op) begin
         // A request left hanging is remembered so its late ack can be thrown away.
         r_pc         <= w_target;
         r_ifid_valid <= 1'b0;
         r_pending    <= 1'b0;
         r_drop       <= w_req && !imem_ack;
         r_drop_addr  <= imem_addr;
      end else if (if_flush) begin
         r_ifid_valid <= 1'b0;
         r_pending    <= w_pend_next;
         r_drop       <= w_drop_next;
      end else if (stall) begin
         r_pending <= w_pend_next;
         r_drop    <= w_drop_next;
         if (w_take) begin
            r_pc <= w_pc_seq;
         end
      end else begin
         r_pending <= w_pend_next;
         r_drop    <= w_drop_next;
         if (w_skid_full) begin
            r_ifid_instr <= w_skid_instr;
            r_ifid_pc    <= w_skid_pc;
            r_ifid_valid <= 1'b1;
         end else if (w_take) begin
            r_ifid_instr <= imem_rdata;
            r_ifid_pc    <= r_pc;
            r_ifid_valid <= 1'b1;
            r_pc         <= w_pc_seq;
         end else begin
            r_ifid_valid <= 1'b0;
         end
      end
   end

   assign imem_req    = w_req;
   assign imem_addr   = r_drop ? r_drop_addr : r_pc;
   assign ifid_instr  = r_ifid_instr;
   assign ifid_pc     = r_ifid_pc;
   assign ifid_valid  = r_ifid_valid;
   assign halted      = r_halted;
   assign fault       = r_fault;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: sequential fetch, branch/jump redirects,
// dropped late ack, stall skid, halt/fault and PC wrap.
module tb_fetch_sequencer;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        pc_op;
   logic        b_jmp;
   logic        if_flush;
   logic        halt;
   logic        ovf_err;
   logic [15:0] br_offset;
   logic [15:0] jmp_target;
   logic [15:0] imem_addr;
   logic        imem_req;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic [15:0] ifid_instr;
   logic [15:0] ifid_pc;
   logic        ifid_valid;
   logic        halted;
   logic        fault;
   logic [1:0]  dbg_state;

   logic        use_fixed;
   logic [15:0] fixed_rdata;
   int          n_vec;
   int          n_err;
   bit          done;

   fetch_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .pc_op       (pc_op),
      .b_jmp       (b_jmp),
      .if_flush    (if_flush),
      .halt        (halt),
      .ovf_err     (ovf_err),
      .br_offset   (br_offset),
      .jmp_target  (jmp_target),
      .imem_addr   (imem_addr),
      .imem_req    (imem_req),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .ifid_instr  (ifid_instr),
      .ifid_pc     (ifid_pc),
      .ifid_valid  (ifid_valid),
      .halted      (halted),
      .fault       (fault),
      .o_dbg_state (dbg_state)
   );

   // clock / memory model
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      imem_rdata = use_fixed ? fixed_rdata : (16'h1000 ^ imem_addr);
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      reset = 1'b0; stall = 1'b0; pc_op = 1'b0; b_jmp = 1'b0; if_flush = 1'b0;
      halt = 1'b0; ovf_err = 1'b0; br_offset = '0; jmp_target = '0;
      imem_ack = 1'b0; use_fixed = 1'b0; fixed_rdata = '0;
      tick();
      tick();
      n_vec++;
      if (imem_req !== 1'b0) begin
         n_err++; $display("FAIL reset_req: got %b want 0", imem_req);
      end
      n_vec++;
      if (ifid_valid !== 1'b0 || ifid_pc !== 16'h0 || ifid_instr !== 16'h0) begin
         n_err++; $display("FAIL reset_ifid: got v=%b pc=%h i=%h want 0/0000/0000", ifid_valid, ifid_pc, ifid_instr);
      end
      n_vec++;
      if (halted !== 1'b0 || fault !== 1'b0 || imem_addr !== 16'h0000) begin
         n_err++; $display("FAIL reset_flags: got h=%b f=%b a=%h want 0/0/0000", halted, fault, imem_addr);
      end
      reset = 1'b1;
   endtask

   task automatic test_seq_fetch();
      imem_ack = 1'b1;
      #1;
      n_vec++;
      if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
         n_err++; $display("FAIL seq_first_req: got req=%b a=%h want 1/0000", imem_req, imem_addr);
      end
      for (int k = 0; k < 4; k++) begin
         tick();
         n_vec++;
         if (ifid_valid !== 1'b1 || ifid_pc !== 16'(2*k) || ifid_instr !== (16'h1000 ^ 16'(2*k))
             || imem_addr !== 16'(2*k+2)) begin
            n_err++; $display("FAIL seq_fetch%0d: got v=%b pc=%h i=%h a=%h want 1/%h/%h/%h", k,
                              ifid_valid, ifid_pc, ifid_instr, imem_addr, 16'(2*k),
                              16'h1000 ^ 16'(2*k), 16'(2*k+2));
         end
      end
   endtask

   task automatic test_branch();
      for (int k = 0; k < 5; k++) tick();
      n_vec++;
      if (ifid_pc !== 16'h0010 || ifid_valid !== 1'b1) begin
         n_err++; $display("FAIL br_setup: got pc=%h v=%b want 0010/1", ifid_pc, ifid_valid);
      end
      pc_op = 1'b1; b_jmp = 1'b1; br_offset = 16'hFFFD;
      tick();
      pc_op = 1'b0; b_jmp = 1'b0; br_offset = '0;
      n_vec++;
      if (imem_addr !== 16'h000C || ifid_valid !== 1'b0 || imem_req !== 1'b1) begin
         n_err++; $display("FAIL br_redirect: got a=%h v=%b req=%b want 000C/0/1", imem_addr, ifid_valid, imem_req);
      end
      tick();
      n_vec++;
      if (ifid_valid !== 1'b1 || ifid_pc !== 16'h000C || ifid_instr !== 16'h100C) begin
         n_err++; $display("FAIL br_land: got v=%b pc=%h i=%h want 1/000C/100C", ifid_valid, ifid_pc, ifid_instr);
      end
   endtask

   task automatic test_late_ack_drop();
      imem_ack = 1'b0;
      tick();
      pc_op = 1'b1; b_jmp = 1'b0; jmp_target = 16'h0100;
      tick();
      pc_op = 1'b0; jmp_target = '0;
      n_vec++;
      if (imem_addr !== 16'h000E || imem_req !== 1'b1) begin
         n_err++; $display("FAIL drop_hold: got a=%h req=%b want 000E/1", imem_addr, imem_req);
      end
      tick();
      imem_ack = 1'b1;
      tick();
      n_vec++;
      if (imem_addr !== 16'h0100 || imem_req !== 1'b1 || ifid_valid !== 1'b0) begin
         n_err++; $display("FAIL drop_stale: got a=%h req=%b v=%b want 0100/1/0", imem_addr, imem_req, ifid_valid);
      end
      tick();
      n_vec++;
      if (ifid_valid !== 1'b1 || ifid_pc !== 16'h0100 || ifid_instr !== 16'h1100) begin
         n_err++; $display("FAIL drop_target: got v=%b pc=%h i=%h want 1/0100/1100", ifid_valid, ifid_pc, ifid_instr);
      end
   endtask

   task automatic test_stall_skid();
      imem_ack = 1'b0;
      tick();
      stall = 1'b1;
      #1;
      n_vec++;
      if (imem_req !== 1'b1 || imem_addr !== 16'h0102) begin
         n_err++; $display("FAIL stall_pending: got req=%b a=%h want 1/0102", imem_req, imem_addr);
      end
      tick();
      use_fixed = 1'b1; fixed_rdata = 16'hABCD; imem_ack = 1'b1;
      tick();
      n_vec++;
      if (imem_req !== 1'b0 || ifid_instr !== 16'h1100 || ifid_pc !== 16'h0100) begin
         n_err++; $display("FAIL stall_hold: got req=%b i=%h pc=%h want 0/1100/0100", imem_req, ifid_instr, ifid_pc);
      end
      stall = 1'b0; use_fixed = 1'b0;
      #1;
      n_vec++;
      if (imem_req !== 1'b0) begin
         n_err++; $display("FAIL skid_block: got req=%b want 0", imem_req);
      end
      tick();
      n_vec++;
      if (ifid_valid !== 1'b1 || ifid_instr !== 16'hABCD || ifid_pc !== 16'h0102 || imem_addr !== 16'h0104) begin
         n_err++; $display("FAIL skid_pop: got v=%b i=%h pc=%h a=%h want 1/ABCD/0102/0104",
                           ifid_valid, ifid_instr, ifid_pc, imem_addr);
      end
      tick();
      n_vec++;
      if (ifid_valid !== 1'b1 || ifid_pc !== 16'h0104 || ifid_instr !== 16'h1104) begin
         n_err++; $display("FAIL skid_next: got v=%b pc=%h i=%h want 1/0104/1104", ifid_valid, ifid_pc, ifid_instr);
      end
   endtask

   task automatic test_halt_fault();
      halt = 1'b1;
      tick();
      halt = 1'b0;
      n_vec++;
      if (halted !== 1'b1 || fault !== 1'b0 || imem_req !== 1'b0 || ifid_valid !== 1'b0 || dbg_state !== 2'd1) begin
         n_err++; $display("FAIL halt: got h=%b f=%b req=%b v=%b st=%0d want 1/0/0/0/1",
                           halted, fault, imem_req, ifid_valid, dbg_state);
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         n_vec++;
         if (imem_req !== 1'b0 || halted !== 1'b1) begin
            n_err++; $display("FAIL halt_stay%0d: got req=%b h=%b want 0/1", k, imem_req, halted);
         end
      end
      ovf_err = 1'b1;
      tick();
      ovf_err = 1'b0;
      n_vec++;
      if (fault !== 1'b1 || halted !== 1'b1 || dbg_state !== 2'd2) begin
         n_err++; $display("FAIL fault: got f=%b h=%b st=%0d want 1/1/2", fault, halted, dbg_state);
      end
      reset = 1'b0;
      tick();
      n_vec++;
      if (halted !== 1'b0 || fault !== 1'b0 || imem_req !== 1'b0) begin
         n_err++; $display("FAIL fault_reset: got h=%b f=%b req=%b want 0/0/0", halted, fault, imem_req);
      end
      reset = 1'b1;
      #1;
      n_vec++;
      if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
         n_err++; $display("FAIL restart: got req=%b a=%h want 1/0000", imem_req, imem_addr);
      end
   endtask

   task automatic test_wrap_and_priority();
      pc_op = 1'b1; b_jmp = 1'b0; jmp_target = 16'hFFFE;
      tick();
      pc_op = 1'b0; jmp_target = '0;
      n_vec++;
      if (imem_addr !== 16'hFFFE || ifid_valid !== 1'b0) begin
         n_err++; $display("FAIL wrap_jump: got a=%h v=%b want FFFE/0", imem_addr, ifid_valid);
      end
      tick();
      n_vec++;
      if (ifid_pc !== 16'hFFFE || ifid_instr !== 16'hEFFE || imem_addr !== 16'h0000) begin
         n_err++; $display("FAIL wrap_pc: got pc=%h i=%h a=%h want FFFE/EFFE/0000", ifid_pc, ifid_instr, imem_addr);
      end
      tick();
      n_vec++;
      if (ifid_pc !== 16'h0000 || ifid_valid !== 1'b1 || imem_addr !== 16'h0002) begin
         n_err++; $display("FAIL wrap_next: got pc=%h v=%b a=%h want 0000/1/0002", ifid_pc, ifid_valid, imem_addr);
      end
      if_flush = 1'b1;
      tick();
      if_flush = 1'b0;
      n_vec++;
      if (ifid_valid !== 1'b0 || imem_addr !== 16'h0002) begin
         n_err++; $display("FAIL flush: got v=%b a=%h want 0/0002", ifid_valid, imem_addr);
      end
      halt = 1'b1; pc_op = 1'b1; b_jmp = 1'b0; jmp_target = 16'h0200;
      tick();
      halt = 1'b0; pc_op = 1'b0; jmp_target = '0;
      n_vec++;
      if (halted !== 1'b1 || imem_req !== 1'b0 || imem_addr !== 16'h0002 || fault !== 1'b0) begin
         n_err++; $display("FAIL halt_vs_redirect: got h=%b req=%b a=%h f=%b want 1/0/0002/0",
                           halted, imem_req, imem_addr, fault);
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      done  = 1'b0;
      test_reset();
      test_seq_fetch();
      test_branch();
      test_late_ack_drop();
      test_stall_skid();
      test_halt_fault();
      test_wrap_and_priority();
      done = 1'b1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      if (!done) begin
         $display("FAIL watchdog: got no completion by 100000 want completion");
         $fatal(1, "watchdog expired");
      end
   end

endmodule
